// File: rtl/seq_detector_multi.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_multi
// Description : NPAT programmable serial pattern detectors sharing one
//               qualified bit history. Optional match counter enabled
//               by defining SEQ_DET_CNT_EN (hit_cnt tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_multi #(
    parameter  int SEQ_W = 8,
    parameter  int NPAT  = 4,
    parameter  int CNT_W = 8,
    localparam int LEN_W = $clog2(SEQ_W + 1),
    localparam int IDX_W = (NPAT > 1) ? $clog2(NPAT) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [SEQ_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             overlap,
    input  logic             clear,
    input  logic             din_valid,
    input  logic             din,
    output logic [NPAT-1:0]  seen,
    output logic             seen_any,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [SEQ_W-1:0] hist_q;
    logic [SEQ_W-1:0] hist_d;
    logic [SEQ_W-1:0] hist_n;
    logic [NPAT-1:0]  wr_sel;
    logic [NPAT-1:0]  match;
    logic [NPAT-1:0]  seen_q;
    logic             seen_any_q;

    // Candidate history including the incoming bit; matches are judged on it.
    assign hist_n = din_valid ? {hist_q[SEQ_W-2:0], din} : hist_q;

    always_comb begin
        hist_d = hist_n;
        if (clear) begin
            hist_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hist_q     <= '0;
            seen_q     <= '0;
            seen_any_q <= 1'b0;
        end else begin
            hist_q     <= hist_d;
            seen_q     <= match;
            seen_any_q <= |match;
        end
    end

    generate
        for (genvar i = 0; i < NPAT; i++) begin : g_slot
            logic [SEQ_W-1:0] pat_q;
            logic [LEN_W-1:0] len_q;
            logic [LEN_W-1:0] fill_q;
            logic [LEN_W-1:0] fill_d;
            logic [SEQ_W-1:0] mask;
            logic             len_ok;
            logic             filled;
            logic             bits_eq;
            logic             fill_sat;

            // Out-of-range cfg_idx never equals a real slot, so it is ignored.
            assign wr_sel[i] = cfg_we && (int'(cfg_idx) == i);

            always_comb begin
                mask = '0;
                for (int b = 0; b < SEQ_W; b++) begin
                    mask[b] = (b < int'(len_q));
                end
            end

            assign len_ok   = (len_q != '0) && (int'(len_q) <= SEQ_W);
            assign filled   = ((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
            assign bits_eq  = ((hist_n ^ pat_q) & mask) == '0;
            assign fill_sat = int'(fill_q) >= SEQ_W;

            assign match[i] = din_valid && !clear && !wr_sel[i]
                              && len_ok && filled && bits_eq;

            always_comb begin
                fill_d = fill_q;
                if (clear || wr_sel[i]) begin
                    fill_d = '0;
                end else if (din_valid) begin
                    if (match[i] && !overlap) begin
                        fill_d = '0;
                    end else if (!fill_sat) begin
                        fill_d = fill_q + LEN_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    pat_q  <= '0;
                    len_q  <= '0;
                    fill_q <= '0;
                end else begin
                    if (wr_sel[i]) begin
                        pat_q <= cfg_pat;
                        len_q <= cfg_len;
                    end
                    fill_q <= fill_d;
                end
            end
        end
    endgenerate

    assign seen     = seen_q;
    assign seen_any = seen_any_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // One count per matching cycle, however many slots fire in it.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if ((|match) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt = cnt_q;
`else
    assign hit_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_multi
// Description : Directed and randomized checks of seq_detector_multi against
//               a behavioural model of the detection rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_multi;

    localparam int SEQ_W   = 8;
    localparam int NPAT    = 4;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(SEQ_W + 1);
    localparam int IDX_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int HMASK   = (1 << SEQ_W) - 1;
`ifdef SEQ_DET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk;
    logic             resetn;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [SEQ_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             overlap;
    logic             clear;
    logic             din_valid;
    logic             din;
    logic [NPAT-1:0]  seen;
    logic             seen_any;
    logic [CNT_W-1:0] hit_cnt;

    int n_checks;
    int n_errors;

    // Reference state: history as an integer, per-slot bits-since-restart.
    int m_hist;
    int m_pat  [NPAT];
    int m_len  [NPAT];
    int m_fill [NPAT];
    int m_seen;
    int m_any;
    int m_cnt;

    seq_detector_multi #(
        .SEQ_W (SEQ_W),
        .NPAT  (NPAT),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .overlap   (overlap),
        .clear     (clear),
        .din_valid (din_valid),
        .din       (din),
        .seen      (seen),
        .seen_any  (seen_any),
        .hit_cnt   (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  hn;
        int  nseen;
        int  lm;
        bit  wr;
        if (!resetn) begin
            m_hist = 0;
            for (int i = 0; i < NPAT; i++) begin
                m_pat[i] = 0; m_len[i] = 0; m_fill[i] = 0;
            end
            m_seen = 0; m_any = 0; m_cnt = 0;
        end else begin
            hn    = din_valid ? (((m_hist << 1) | int'(din)) & HMASK) : m_hist;
            nseen = 0;
            for (int i = 0; i < NPAT; i++) begin
                wr = cfg_we && (int'(cfg_idx) == i);
                if (din_valid && !clear && !wr && m_len[i] >= 1 && m_len[i] <= SEQ_W
                    && m_fill[i] + 1 >= m_len[i]) begin
                    lm = (1 << m_len[i]) - 1;
                    if ((hn & lm) == (m_pat[i] & lm)) nseen |= (1 << i);
                end
            end
            for (int i = 0; i < NPAT; i++) begin
                wr = cfg_we && (int'(cfg_idx) == i);
                if (clear || wr) m_fill[i] = 0;
                else if (din_valid) begin
                    if (((nseen >> i) & 1) == 1 && !overlap) m_fill[i] = 0;
                    else if (m_fill[i] < SEQ_W) m_fill[i] = m_fill[i] + 1;
                end
                if (wr) begin
                    m_pat[i] = int'(cfg_pat);
                    m_len[i] = int'(cfg_len);
                end
            end
            m_hist = clear ? 0 : hn;
            if (clear) m_cnt = 0;
            else if (nseen != 0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            m_seen = nseen;
            m_any  = (nseen != 0) ? 1 : 0;
        end
    endtask

    task automatic cycle(input bit v, input bit d);
        din_valid = v;
        din       = d;
        model_step();
        @(posedge clk);
        #1;
        check_eq("seen", 32'(seen), m_seen);
        check_eq("seen_any", 32'(seen_any), m_any);
        check_eq("hit_cnt", 32'(hit_cnt), CNT_EN ? m_cnt : 0);
        cfg_we = 1'b0;
        clear  = 1'b0;
    endtask

    task automatic cfg(input int idx, input int pat, input int len);
        cfg_we  = 1'b1;
        cfg_idx = IDX_W'(idx);
        cfg_pat = SEQ_W'(pat);
        cfg_len = LEN_W'(len);
    endtask

    initial begin
        logic [4:0] exp5;
        logic [4:0] bits5;
        logic [3:0] sb;
        n_checks  = 0;
        n_errors  = 0;
        resetn    = 1'b0;
        cfg_we    = 1'b0;
        cfg_idx   = '0;
        cfg_pat   = '0;
        cfg_len   = '0;
        overlap   = 1'b0;
        clear     = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;

        cycle(0, 0);
        cycle(0, 0);
        resetn = 1'b1;
        cycle(1, 1);
        check_eq("post_rst_seen", 32'(seen), 0);

        // Overlapping 101 on 1,0,1,0,1
        bits5 = 5'b10101;
        cfg(0, 'b101, 3); clear = 1'b1; overlap = 1'b1;
        cycle(0, 0);
        exp5 = 5'b10100;
        for (int k = 0; k < 5; k++) begin
            cycle(1, bits5[k]);
            check_eq("ovl_seen0", 32'(seen[0]), 32'(exp5[k]));
        end
        check_eq("ovl_cnt", 32'(hit_cnt), CNT_EN ? 2 : 0);

        // Non-overlapping
        clear = 1'b1; overlap = 1'b0;
        cycle(0, 0);
        exp5 = 5'b00100;
        for (int k = 0; k < 5; k++) begin
            cycle(1, bits5[k]);
            check_eq("novl_seen0", 32'(seen[0]), 32'(exp5[k]));
        end
        check_eq("novl_cnt", 32'(hit_cnt), CNT_EN ? 1 : 0);

        // Two slots, bits 1,1,0,1 separated by unqualified cycles
        clear = 1'b1; cfg(0, 'b1101, 4);
        cycle(0, 0);
        cfg(1, 'b01, 2);
        cycle(0, 0);
        sb = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            cycle(1, sb[k]);
            check_eq("sim_seen", 32'(seen), (k == 3) ? 32'h3 : 32'h0);
            cycle(0, 0);
            check_eq("gap_seen", 32'(seen), 0);
        end
        check_eq("sim_cnt", 32'(hit_cnt), CNT_EN ? 1 : 0);

        // Fill guard on an all-zero 8-bit pattern, then len 9 disables
        resetn = 1'b0;
        cycle(1, 1);
        check_eq("rst_any", 32'(seen_any), 0);
        resetn = 1'b1;
        cfg(0, 0, 8);
        cycle(0, 0);
        for (int k = 0; k < 8; k++) begin
            cycle(1, 0);
            check_eq("fill_seen0", 32'(seen[0]), (k == 7) ? 1 : 0);
        end
        cfg(0, 0, 9);
        cycle(0, 0);
        for (int k = 0; k < 10; k++) begin
            cycle(1, 0);
            check_eq("len9_seen0", 32'(seen[0]), 0);
        end

        // Config write on the completing bit, then clear mid-pattern
        clear = 1'b1; cfg(0, 'b11, 2);
        cycle(0, 0);
        cfg(1, 'b1, 1);
        cycle(0, 0);
        cycle(1, 1);
        check_eq("cw_seen_a", 32'(seen), 32'h2);
        cfg(0, 'b11, 2);
        cycle(1, 1);
        check_eq("cw_seen_b", 32'(seen), 32'h2);
        cycle(1, 1);
        check_eq("clr_seen0_a", 32'(seen[0]), 0);
        clear = 1'b1;
        cycle(1, 1);
        check_eq("clr_seen", 32'(seen), 0);
        cycle(1, 1);
        check_eq("clr_seen0_b", 32'(seen[0]), 0);
        cycle(1, 1);
        check_eq("clr_seen0_c", 32'(seen[0]), 1);

        // Counter saturation
        clear = 1'b1;
        cycle(0, 0);
        for (int k = 0; k < 5; k++) cycle(1, 1);
        check_eq("sat_cnt", 32'(hit_cnt), CNT_EN ? 3 : 0);

        // Reset mid-stream disables every slot
        resetn = 1'b0;
        cycle(1, 1);
        check_eq("mrst_cnt", 32'(hit_cnt), 0);
        resetn = 1'b1;
        cycle(1, 1);
        check_eq("mrst_seen", 32'(seen), 0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            resetn = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 19) == 0) begin
                cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                                : int'($urandom_range(1, 4)));
            end
            clear   = ($urandom_range(0, 49) == 0);
            overlap = $urandom_range(0, 1) == 1;
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
